// File: rtl/floo_req_unpacker.sv
// FlooReq link receiver.
// Accepts one request flit per handshake and steers it to the AXI AW, W or AR
// output channel. Each output channel is a one-entry register. A small FSM
// makes sure the W beats of a write follow their AW. Flits that break that
// rule, or that carry a B/R/undefined channel code, are consumed and counted.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flit_valid_i/ready_o   flit handshake
//   flit_axi_ch_i          channel code (axi_ch_e)
//   flit_last_i            last beat of a W burst
//   flit_payload_i         LSB-aligned channel payload
//   aw_*/w_*/ar_*          registered AXI output channels (valid/ready/data)
//   wr_burst_o             high while W beats are expected
//   err_o                  one-cycle pulse after a flit is dropped
//   err_cnt_o              saturating count of dropped flits

package axi_pkg;

  typedef enum logic [2:0] {
    AxiAw = 3'd0,
    AxiW  = 3'd1,
    AxiAr = 3'd2,
    AxiB  = 3'd3,
    AxiR  = 3'd4
  } axi_ch_e;

  // id, addr, len, size, burst, lock, cache, prot, qos, region, atop, user
  function automatic int unsigned aw_width(input int unsigned addr_w,
                                           input int unsigned id_w,
                                           input int unsigned user_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + 6 + user_w;
  endfunction

  // data, strb, last, user
  function automatic int unsigned w_width(input int unsigned data_w,
                                          input int unsigned user_w);
    return data_w + data_w / 8 + 1 + user_w;
  endfunction

  // id, addr, len, size, burst, lock, cache, prot, qos, region, user
  function automatic int unsigned ar_width(input int unsigned addr_w,
                                           input int unsigned id_w,
                                           input int unsigned user_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + user_w;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

module floo_req_unpacker
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned UserWidth    = 1,
  localparam int unsigned AwWidth      = axi_pkg::aw_width(AddrWidth, IdWidth, UserWidth),
  localparam int unsigned WWidth       = axi_pkg::w_width(DataWidth, UserWidth),
  localparam int unsigned ArWidth      = axi_pkg::ar_width(AddrWidth, IdWidth, UserWidth),
  localparam int unsigned PayloadWidth = axi_pkg::max3(AwWidth, WWidth, ArWidth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flit_valid_i,
  output logic                    flit_ready_o,
  input  logic [2:0]              flit_axi_ch_i,
  input  logic                    flit_last_i,
  input  logic [PayloadWidth-1:0] flit_payload_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AwWidth-1:0]      aw_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [WWidth-1:0]       w_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ArWidth-1:0]      ar_o,
  output logic                    wr_burst_o,
  output logic                    err_o,
  output logic [7:0]              err_cnt_o
);

  typedef enum logic {Idle, WBurst} state_e;

  state_e               state_q, state_d;
  logic                 aw_valid_q, w_valid_q, ar_valid_q;
  logic [AwWidth-1:0]   aw_q;
  logic [WWidth-1:0]    w_q;
  logic [ArWidth-1:0]   ar_q;
  logic                 err_q;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic aw_free, w_free, ar_free;
  logic legal_aw, legal_w, legal_ar, illegal;
  logic hs, load_aw, load_w, load_ar, drop;

  // The top payload bit is reserved and never carries channel data.
  logic unused_rsvd;
  assign unused_rsvd = flit_payload_i[PayloadWidth-1];

  // A register is free if empty or being drained this cycle.
  assign aw_free = !aw_valid_q || aw_ready_i;
  assign w_free  = !w_valid_q  || w_ready_i;
  assign ar_free = !ar_valid_q || ar_ready_i;

  assign legal_aw = (flit_axi_ch_i == AxiAw) && (state_q == Idle);
  assign legal_ar = (flit_axi_ch_i == AxiAr) && (state_q == Idle);
  assign legal_w  = (flit_axi_ch_i == AxiW)  && (state_q == WBurst);
  assign illegal  = !(legal_aw || legal_w || legal_ar);

  // Illegal flits are always taken so a bad stream can never wedge the link.
  always_comb begin
    flit_ready_o = illegal
                 | (legal_aw & aw_free)
                 | (legal_w  & w_free)
                 | (legal_ar & ar_free);
  end

  assign hs      = flit_valid_i & flit_ready_o;
  assign load_aw = hs & legal_aw;
  assign load_w  = hs & legal_w;
  assign load_ar = hs & legal_ar;
  assign drop    = hs & illegal;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (load_aw)                state_d = WBurst;
      WBurst:  if (load_w && flit_last_i)  state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      err_q     <= drop;
      err_cnt_q <= err_cnt_d;
      // Load wins over drain: refill in the same cycle keeps full throughput.
      if (load_aw)         aw_valid_q <= 1'b1;
      else if (aw_ready_i) aw_valid_q <= 1'b0;
      if (load_w)          w_valid_q  <= 1'b1;
      else if (w_ready_i)  w_valid_q  <= 1'b0;
      if (load_ar)         ar_valid_q <= 1'b1;
      else if (ar_ready_i) ar_valid_q <= 1'b0;
    end
  end

  // Data registers carry no reset; they only matter while valid is set.
  always_ff @(posedge clk_i) begin
    if (load_aw) aw_q <= flit_payload_i[AwWidth-1:0];
    if (load_w)  w_q  <= flit_payload_i[WWidth-1:0];
    if (load_ar) ar_q <= flit_payload_i[ArWidth-1:0];
  end

  assign aw_valid_o = aw_valid_q;
  assign w_valid_o  = w_valid_q;
  assign ar_valid_o = ar_valid_q;
  assign aw_o       = aw_q;
  assign w_o        = w_q;
  assign ar_o       = ar_q;
  assign wr_burst_o = (state_q == WBurst);
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_floo_req_unpacker.sv
// Randomized and directed bench for floo_req_unpacker with a queue-based
// reference model: each output channel is an expected-item queue, and the
// write-burst rule is tracked as a single "inside a burst" flag.
module tb_floo_req_unpacker;
  import axi_pkg::*;

  localparam int unsigned AW  = 48;
  localparam int unsigned DW  = 64;
  localparam int unsigned IW  = 4;
  localparam int unsigned UW  = 1;
  localparam int unsigned AwW = aw_width(AW, IW, UW);
  localparam int unsigned WW  = w_width(DW, UW);
  localparam int unsigned ArW = ar_width(AW, IW, UW);
  localparam int unsigned PW  = max3(AwW, WW, ArW) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flit_valid_i = 1'b0;
  logic          flit_ready_o;
  logic [2:0]    flit_axi_ch_i = 3'd0;
  logic          flit_last_i = 1'b0;
  logic [PW-1:0] flit_payload_i = '0;
  logic          aw_valid_o, w_valid_o, ar_valid_o;
  logic          aw_ready_i = 1'b1, w_ready_i = 1'b1, ar_ready_i = 1'b1;
  logic [AwW-1:0] aw_o;
  logic [WW-1:0]  w_o;
  logic [ArW-1:0] ar_o;
  logic          wr_burst_o, err_o;
  logic [7:0]    err_cnt_o;

  always #5 clk = ~clk;

  floo_req_unpacker #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .flit_valid_i(flit_valid_i), .flit_ready_o(flit_ready_o),
    .flit_axi_ch_i(flit_axi_ch_i), .flit_last_i(flit_last_i),
    .flit_payload_i(flit_payload_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_o(aw_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_o(w_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_o(ar_o),
    .wr_burst_o(wr_burst_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] q_aw[$], q_w[$], q_ar[$];
  bit            m_burst;
  bit            m_err;
  int            m_cnt;

  function automatic bit is_legal(input logic [2:0] ch, input bit in_burst);
    case (ch)
      3'd0, 3'd2: return !in_burst;  // AW / AR only between bursts
      3'd1:       return in_burst;   // W only inside a burst
      default:    return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    bit legal, exp_rdy, hs;
    if (!rst_n) begin
      chk("rst_aw_valid", 128'(aw_valid_o), 128'(0));
      chk("rst_w_valid",  128'(w_valid_o),  128'(0));
      chk("rst_ar_valid", 128'(ar_valid_o), 128'(0));
      chk("rst_wr_burst", 128'(wr_burst_o), 128'(0));
      chk("rst_err",      128'(err_o),      128'(0));
      chk("rst_err_cnt",  128'(err_cnt_o),  128'(0));
      q_aw.delete(); q_w.delete(); q_ar.delete();
      m_burst = 0; m_err = 0; m_cnt = 0;
    end else begin
      legal = is_legal(flit_axi_ch_i, m_burst);
      case (flit_axi_ch_i)
        3'd0:    exp_rdy = !legal || q_aw.size() == 0 || aw_ready_i;
        3'd1:    exp_rdy = !legal || q_w.size()  == 0 || w_ready_i;
        3'd2:    exp_rdy = !legal || q_ar.size() == 0 || ar_ready_i;
        default: exp_rdy = 1'b1;
      endcase
      chk("flit_ready", 128'(flit_ready_o), 128'(exp_rdy));
      chk("aw_valid", 128'(aw_valid_o), 128'(q_aw.size() != 0));
      chk("w_valid",  128'(w_valid_o),  128'(q_w.size()  != 0));
      chk("ar_valid", 128'(ar_valid_o), 128'(q_ar.size() != 0));
      if (q_aw.size() != 0) chk("aw_data", 128'(aw_o), 128'(q_aw[0][AwW-1:0]));
      if (q_w.size()  != 0) chk("w_data",  128'(w_o),  128'(q_w[0][WW-1:0]));
      if (q_ar.size() != 0) chk("ar_data", 128'(ar_o), 128'(q_ar[0][ArW-1:0]));
      chk("wr_burst", 128'(wr_burst_o), 128'(m_burst));
      chk("err",      128'(err_o),      128'(m_err));
      chk("err_cnt",  128'(err_cnt_o),  128'(m_cnt));
      // advance to the next edge: drain first, then accept
      if (q_aw.size() != 0 && aw_ready_i) void'(q_aw.pop_front());
      if (q_w.size()  != 0 && w_ready_i)  void'(q_w.pop_front());
      if (q_ar.size() != 0 && ar_ready_i) void'(q_ar.pop_front());
      hs = flit_valid_i && exp_rdy;
      m_err = hs && !legal;
      if (hs && !legal && m_cnt < 255) m_cnt++;
      if (hs && legal) begin
        case (flit_axi_ch_i)
          3'd0:    begin q_aw.push_back(flit_payload_i); m_burst = 1; end
          3'd1:    begin q_w.push_back(flit_payload_i); if (flit_last_i) m_burst = 0; end
          default: q_ar.push_back(flit_payload_i);
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [PW-1:0] rnd_pl();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // Present a flit and hold it until accepted; returns at edge+1 after handshake.
  task automatic flit(input logic [2:0] ch, input logic last, input logic [PW-1:0] pl);
    logic r;
    int   n;
    flit_valid_i = 1'b1; flit_axi_ch_i = ch; flit_last_i = last; flit_payload_i = pl;
    n = 0;
    do begin
      @(negedge clk); r = flit_ready_o;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    if (!r) begin
      errors++;
      $display("FAIL flit_timeout actual=stalled required=accept ch=%0d", ch);
    end
    flit_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    flit_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    flit_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  logic [PW-1:0] p1, p2;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Normal write, all readies high
    flit(3'd0, 1'b0, rnd_pl());
    chk("wr_aw_lat",    128'(aw_valid_o), 128'(1));
    chk("wr_burst_on",  128'(wr_burst_o), 128'(1));
    flit(3'd1, 1'b0, rnd_pl());
    chk("wr_w1_lat",    128'(w_valid_o),  128'(1));
    chk("wr_burst_mid", 128'(wr_burst_o), 128'(1));
    flit(3'd1, 1'b1, rnd_pl());
    chk("wr_w2_lat",    128'(w_valid_o),  128'(1));
    chk("wr_burst_off", 128'(wr_burst_o), 128'(0));
    chk("wr_err_cnt",   128'(err_cnt_o),  128'(0));
    idle(2);

    // AR backpressure
    p1 = rnd_pl(); p2 = rnd_pl();
    ar_ready_i = 1'b0;
    flit(3'd2, 1'b0, p1);
    flit_valid_i = 1'b1; flit_axi_ch_i = 3'd2; flit_payload_i = p2;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", 128'(flit_ready_o), 128'(0));
      chk("bp_ar_hold",   128'(ar_o),         128'(p1[ArW-1:0]));
      @(posedge clk); #1;
    end
    ar_ready_i = 1'b1;
    flit(3'd2, 1'b0, p2);
    chk("bp_ar2_valid", 128'(ar_valid_o), 128'(1));
    chk("bp_ar2_data",  128'(ar_o),       128'(p2[ArW-1:0]));
    idle(2);

    // Illegal flits in IDLE
    do_reset(2);
    flit(3'd1, 1'b1, rnd_pl());
    chk("ill_w_err",     128'(err_o),     128'(1));
    chk("ill_w_cnt",     128'(err_cnt_o), 128'(1));
    chk("ill_w_novalid", 128'(w_valid_o), 128'(0));
    flit(3'd6, 1'b0, rnd_pl());
    chk("ill_6_cnt",     128'(err_cnt_o),  128'(2));
    chk("ill_6_idle",    128'(wr_burst_o), 128'(0));
    idle(2);

    // Interleave violation
    do_reset(2);
    flit(3'd0, 1'b0, rnd_pl());
    flit(3'd2, 1'b0, rnd_pl());
    chk("ilv_cnt",   128'(err_cnt_o),  128'(1));
    chk("ilv_burst", 128'(wr_burst_o), 128'(1));
    chk("ilv_no_ar", 128'(ar_valid_o), 128'(0));
    flit(3'd1, 1'b1, rnd_pl());
    chk("ilv_w_ok",  128'(w_valid_o),  128'(1));
    chk("ilv_idle",  128'(wr_burst_o), 128'(0));
    idle(2);

    // Reset mid-burst
    do_reset(2);
    flit(3'd0, 1'b0, rnd_pl());
    flit(3'd1, 1'b0, rnd_pl());
    do_reset(1);
    chk("rmb_burst", 128'(wr_burst_o), 128'(0));
    chk("rmb_w",     128'(w_valid_o),  128'(0));
    flit(3'd1, 1'b1, rnd_pl());
    chk("rmb_w_err", 128'(err_cnt_o),  128'(1));
    idle(2);

    // Saturation with 300 B flits
    do_reset(2);
    for (int i = 0; i < 300; i++) flit(3'd3, 1'b0, rnd_pl());
    chk("sat_cnt", 128'(err_cnt_o), 128'(255));
    idle(2);

    // Randomized traffic
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      flit_valid_i   = ($urandom_range(0, 3) != 0);
      flit_axi_ch_i  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(0, 2));
      flit_last_i    = ($urandom_range(0, 2) == 0);
      flit_payload_i = rnd_pl();
      aw_ready_i     = ($urandom_range(0, 3) != 0);
      w_ready_i      = ($urandom_range(0, 3) != 0);
      ar_ready_i     = ($urandom_range(0, 3) != 0);
      if (i == 1500) do_reset(1);
      @(posedge clk); #1;
    end
    aw_ready_i = 1'b1; w_ready_i = 1'b1; ar_ready_i = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
